// File: rtl/cyq_key_debounce8.sv
// Eight-key debouncer feeding an active-low 8-to-3 priority encoder.
// Define CYQ_KEY_LATCH_EN to latch accepted presses in I until LCLR.
module cyq_key_debounce8 #(
  parameter int DB_MAX = 50000,
  parameter int CNT_W  = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [0:7] KEY,
  input  logic       LCLR,
  output logic [0:7] I,
  output logic       STB,
  output logic       ANY
);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } st_e;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_MAX - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_SAT  = '1;

  logic [0:7]       r_s1;
  logic [0:7]       r_s2;
  st_e              r_st     [8];
  st_e              w_st_nx  [8];
  logic [CNT_W-1:0] r_cnt    [8];
  logic [CNT_W-1:0] w_cnt_nx [8];
  logic [0:7]       w_acc;
  logic [0:7]       w_held;
  logic [0:7]       w_held_nx;
  logic [0:7]       r_i;
  logic             r_stb;
  logic             r_any;

  function automatic logic [CNT_W-1:0] f_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == LP_SAT) ? c : c + LP_ONE;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= KEY;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < 8; k++) begin
        r_st[k]  <= REL;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        r_st[k]  <= w_st_nx[k];
        r_cnt[k] <= w_cnt_nx[k];
      end
    end
  end

  // Entering a candidate state already counts its first differing cycle,
  // so acceptance lands exactly DB_MAX cycles after the synced edge.
  always_comb begin
    w_acc     = '0;
    w_held    = '0;
    w_held_nx = '0;
    for (int k = 0; k < 8; k++) begin
      w_st_nx[k]  = r_st[k];
      w_cnt_nx[k] = r_cnt[k];
      unique case (r_st[k])
        REL: begin
          w_cnt_nx[k] = '0;
          if (!r_s2[k]) begin
            if (DB_MAX <= 1) begin
              w_st_nx[k] = PRS;
            end else begin
              w_st_nx[k]  = CHK_P;
              w_cnt_nx[k] = LP_ONE;
            end
          end
        end
        CHK_P: begin
          if (r_s2[k]) begin
            w_st_nx[k]  = REL;
            w_cnt_nx[k] = '0;
          end else if (r_cnt[k] == LP_LAST) begin
            w_st_nx[k]  = PRS;
            w_cnt_nx[k] = '0;
          end else begin
            w_cnt_nx[k] = f_inc(r_cnt[k]);
          end
        end
        PRS: begin
          w_cnt_nx[k] = '0;
          if (r_s2[k]) begin
            if (DB_MAX <= 1) begin
              w_st_nx[k] = REL;
            end else begin
              w_st_nx[k]  = CHK_R;
              w_cnt_nx[k] = LP_ONE;
            end
          end
        end
        CHK_R: begin
          if (!r_s2[k]) begin
            w_st_nx[k]  = PRS;
            w_cnt_nx[k] = '0;
          end else if (r_cnt[k] == LP_LAST) begin
            w_st_nx[k]  = REL;
            w_cnt_nx[k] = '0;
          end else begin
            w_cnt_nx[k] = f_inc(r_cnt[k]);
          end
        end
        default: begin
          w_st_nx[k]  = REL;
          w_cnt_nx[k] = '0;
        end
      endcase
      w_held[k]    = (r_st[k] == PRS) || (r_st[k] == CHK_R);
      w_held_nx[k] = (w_st_nx[k] == PRS) || (w_st_nx[k] == CHK_R);
      // A release-bounce return from CHK_R is not a new press.
      w_acc[k]     = !w_held[k] && (w_st_nx[k] == PRS);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stb <= 1'b0;
      r_any <= 1'b0;
    end else begin
      r_stb <= |w_acc;
      r_any <= |w_held;
    end
  end

`ifdef CYQ_KEY_LATCH_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_i <= '1;
    end else if (|w_acc) begin
      r_i <= ~w_acc;
    end else if (LCLR) begin
      r_i <= '1;
    end
  end
`else
  logic w_unused_lclr;
  assign w_unused_lclr = LCLR;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_i <= '1;
    end else begin
      r_i <= ~w_held_nx;
    end
  end
`endif

  assign I   = r_i;
  assign STB = r_stb;
  assign ANY = r_any;

endmodule

// File: tb/tb_cyq_key_debounce8.sv
// Bench for cyq_key_debounce8: run-length model plus directed checks.
// Covers both builds depending on CYQ_KEY_LATCH_EN.
module tb_cyq_key_debounce8;

  localparam int DB = 8;
`ifdef CYQ_KEY_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic [0:7] KEY;
  logic       LCLR;
  logic [0:7] I;
  logic       STB;
  logic       ANY;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stb   = 0;
  int s0;

  cyq_key_debounce8 #(.DB_MAX(DB), .CNT_W(4)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .KEY  (KEY),
    .LCLR (LCLR),
    .I    (I),
    .STB  (STB),
    .ANY  (ANY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: a key's accepted level flips once DB consecutive observed
  // samples differ from it; observation is KEY two edges late, 1 in reset.
  typedef struct packed {
    logic [0:7]      stab;
    logic [0:7]      pr;
    logic [7:0][4:0] run;
  } mstep_t;

  function automatic mstep_t f_model(
    input logic [0:7]      obs,
    input logic [0:7]      stab,
    input logic [7:0][4:0] run
  );
    mstep_t r;
    r.stab = stab;
    r.pr   = '0;
    r.run  = run;
    for (int k = 0; k < 8; k++) begin
      if (obs[k] != stab[k]) begin
        if (int'(run[k]) + 1 >= DB) begin
          r.stab[k] = obs[k];
          r.run[k]  = '0;
          r.pr[k]   = ~obs[k];
        end else begin
          r.run[k] = run[k] + 5'd1;
        end
      end else begin
        r.run[k] = '0;
      end
    end
    return r;
  endfunction

  logic [0:7]      m_d1, m_d2, m_stab, m_i;
  logic [7:0][4:0] m_run;
  logic            m_stb, m_any;
  mstep_t          w_m;

  assign w_m = f_model(m_d2, m_stab, m_run);

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_d1   <= '1;
      m_d2   <= '1;
      m_stab <= '1;
      m_run  <= '0;
      m_i    <= '1;
      m_stb  <= 1'b0;
      m_any  <= 1'b0;
    end else begin
      m_d1   <= KEY;
      m_d2   <= m_d1;
      m_stab <= w_m.stab;
      m_run  <= w_m.run;
      m_stb  <= |w_m.pr;
      m_any  <= ~&m_stab;
      if (LATCH)
        m_i <= (|w_m.pr) ? ~w_m.pr : (LCLR ? 8'hFF : m_i);
      else
        m_i <= w_m.stab;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      chk("model_I", I, m_i);
      chk("model_STB", 8'(STB), 8'(m_stb));
      chk("model_ANY", 8'(ANY), 8'(m_any));
      if (STB === 1'b1) n_stb++;
    end
  end

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clr();
    LCLR = 1'b1;
    steps(1);
    LCLR = 1'b0;
    steps(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    KEY   = '1;
    LCLR  = 1'b0;
    RST_N = 1'b0;
    steps(3);
    chk("rst_I", I, 8'hFF);
    chk("rst_STB", 8'(STB), 8'h00);
    chk("rst_ANY", 8'(ANY), 8'h00);
    RST_N = 1'b1;
    steps(4);

    s0 = n_stb;
    KEY[3] = 1'b0;
    steps(9);
    chk("k3_early", I, 8'hFF);
    steps(1);
    chk("k3_I", I, 8'hEF);
    chk("k3_STB", 8'(STB), 8'h01);
    chk("k3_ANY0", 8'(ANY), 8'h00);
    steps(1);
    chk("k3_ANY1", 8'(ANY), 8'h01);
    chk("k3_STB_off", 8'(STB), 8'h00);
    KEY[3] = 1'b1;
    steps(12);
    chk("k3_rel", I, LATCH ? 8'hEF : 8'hFF);
    chk("k3_one_stb", 8'(n_stb - s0), 8'h01);
    clr();

    s0 = n_stb;
    KEY[5] = 1'b0;
    steps(5);
    KEY[5] = 1'b1;
    steps(2);
    KEY[5] = 1'b0;
    steps(9);
    chk("k5_early", I, 8'hFF);
    steps(1);
    chk("k5_I", I, 8'hFB);
    chk("k5_STB", 8'(STB), 8'h01);
    steps(2);
    chk("k5_one_stb", 8'(n_stb - s0), 8'h01);
    KEY[5] = 1'b1;
    steps(12);
    clr();

    s0 = n_stb;
    KEY = 8'b0111_1110;
    steps(10);
    chk("k07_I", I, 8'h7E);
    chk("k07_STB", 8'(STB), 8'h01);
    steps(2);
    chk("k07_one_stb", 8'(n_stb - s0), 8'h01);
    KEY = '1;
    steps(12);
    clr();

    s0 = n_stb;
    KEY[6] = 1'b0;
    steps(7);
    KEY[6] = 1'b1;
    steps(12);
    chk("glitch7_I", I, 8'hFF);
    chk("glitch7_stb", 8'(n_stb - s0), 8'h00);
    KEY[6] = 1'b0;
    steps(8);
    KEY[6] = 1'b1;
    steps(2);
    chk("pulse8_I", I, 8'hFD);
    chk("pulse8_STB", 8'(STB), 8'h01);
    steps(12);
    chk("pulse8_one_stb", 8'(n_stb - s0), 8'h01);
    clr();

    KEY[2] = 1'b0;
    steps(7);
    RST_N = 1'b0;
    #1;
    chk("k2_rst_I", I, 8'hFF);
    chk("k2_rst_ANY", 8'(ANY), 8'h00);
    steps(2);
    RST_N = 1'b1;
    steps(9);
    chk("k2_early", I, 8'hFF);
    steps(1);
    chk("k2_I", I, 8'hDF);
    steps(1);
    chk("k2_ANY", 8'(ANY), 8'h01);
    RST_N = 1'b0;
    #1;
    chk("k2_arst_I", I, 8'hFF);
    chk("k2_arst_ANY", 8'(ANY), 8'h00);
    steps(1);
    RST_N = 1'b1;
    steps(10);
    chk("k2_redb_I", I, 8'hDF);
    steps(1);
    LCLR = 1'b1;
    steps(1);
    LCLR = 1'b0;
    chk("k2_lclr", I, LATCH ? 8'hFF : 8'hDF);
    KEY[2] = 1'b1;
    steps(12);
    clr();

    KEY[4] = 1'b0;
    steps(10);
    chk("k4_I", I, 8'hF7);
    KEY[4] = 1'b1;
    steps(12);
    chk("k4_rel", I, LATCH ? 8'hF7 : 8'hFF);
    LCLR = 1'b1;
    steps(1);
    LCLR = 1'b0;
    chk("k4_clr", I, 8'hFF);
    KEY[1] = 1'b0;
    steps(9);
    LCLR = 1'b1;
    steps(1);
    LCLR = 1'b0;
    chk("k1_pri_I", I, 8'hBF);
    chk("k1_pri_STB", 8'(STB), 8'h01);
    steps(2);
    KEY[1] = 1'b1;
    steps(12);
    clr();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cyq_key_debounce8.md
CYQ_KEY_DEBOUNCE8 -- requirements
Module: cyq_key_debounce8

Interface
REQ-001 The block SHALL have parameter DB_MAX, default 50000, meaning the number of consecutive stable clock cycles needed to accept a key change (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each per-key debounce counter; DB_MAX SHALL be at most 2^CNT_W-1.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port KEY  input  [0:7]  raw mechanical keys, active-low, asynchronous to CLK, bounce expected.
REQ-006 The block SHALL have port LCLR  input  1  synchronous latch clear, active-high; used only when the latch feature is compiled in.
REQ-007 The block SHALL have port I  output  [0:7]  debounced key vector, active-low, bit order matching the downstream 8-to-3 priority encoder input I[0:7].
REQ-008 The block SHALL have port STB  output  1  single-cycle active-high pulse on any accepted press.
REQ-009 The block SHALL have port ANY  output  1  active-high; at least one debounced key currently held.
REQ-010 One clock and one reset: the clock is CLK; reset is RST_N, asynchronous and active-low.

Function
REQ-011 Each KEY bit SHALL pass through a 2-flop synchronizer, reset to 1, before any other use.
REQ-012 Each key SHALL have an independent 4-state FSM: REL (stable high), CHK_P (high-to-low candidate), PRS (stable low), CHK_R (low-to-high candidate).
REQ-013 REL->CHK_P when the synced bit is 0; CHK_P->REL when the synced bit returns to 1 before acceptance, with the counter cleared.
REQ-014 In CHK_P and CHK_R the counter SHALL increment each cycle the synced bit differs from the stable level; when the counter equals DB_MAX-1, the FSM SHALL move to PRS or REL respectively and clear the counter.
REQ-015 PRS->CHK_R and CHK_R->PRS SHALL mirror REQ-013.
REQ-016 Total press latency from a clean KEY edge to the debounced level change SHALL be exactly 2 (sync) + DB_MAX cycles.
REQ-017 A press event for key k SHALL be the cycle in which key k enters PRS; STB SHALL be 1 for exactly that cycle, and for one cycle only when several keys are accepted in the same cycle.
REQ-018 ANY SHALL equal the OR over keys of (state is PRS or CHK_R); registered, with one cycle of latency after the state change.
REQ-019 Counters SHALL saturate and never wrap; a counter SHALL stay 0 in REL and in PRS.
REQ-020 All outputs SHALL be registered; no combinational path from KEY to any output.

Reset
REQ-021 While RST_N=0: all FSMs in REL, counters 0, synchronizers 1, I=8'hFF, STB=0, ANY=0.
REQ-022 Reset assertion mid-debounce SHALL abort it; after release, a key already held low SHALL be re-debounced from REL, taking the full latency of REQ-016.

Configuration
REQ-023 Macro CYQ_KEY_LATCH_EN: when not defined, I[k]=0 exactly while key k is in PRS or CHK_R, and LCLR is ignored.
REQ-024 When CYQ_KEY_LATCH_EN is defined, on a press event I SHALL load all-ones with 0 in every newly accepted key position; releases SHALL not change I.
REQ-025 When CYQ_KEY_LATCH_EN is defined, LCLR=1 SHALL set I to 8'hFF on the next edge; a press event in the same cycle SHALL take priority over LCLR.
REQ-026 STB and ANY behaviour SHALL be identical in both builds.

Verification (DB_MAX=8 for simulation)
REQ-027 KEY[3] clean low step held -> I[3]=0 after exactly 10 cycles; STB pulses once in that cycle; ANY=1 one cycle later.
REQ-028 KEY[5] bounce: low 5, high 2, low steady -> no acceptance at the first glitch; I[5]=0 10 cycles after the final falling edge; only one STB.
REQ-029 KEY[0] and KEY[7] fall on the same edge -> I=8'b0111_1110 (I[0] and I[7] low) in the same cycle; single STB.
REQ-030 Hold KEY[2] low and pulse RST_N low during count 5 -> outputs reset at once; I[2]=0 exactly 10 cycles after release.
REQ-031 With CYQ_KEY_LATCH_EN, press then release KEY[4] -> I stays 8'hF7-equivalent (only I[4]=0) after release; LCLR pulse -> I=8'hFF; LCLR coincident with a KEY[1] acceptance -> only I[1]=0.
